inst_fetch_queue: RTL and testbench

//  Fetch-side driver and line buffer directly downstream of i_cache.

---
 rtl/inst_fetch_queue.sv | 120 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch driver and line buffer behind i_cache. It requests lines at the fetch PC and
// queues them, then hands single instructions to decode. A redirect flushes the queue.
module inst_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          RETRY_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  pc_in,
  output logic         rd_en,
  output logic         abort,
  input  logic [127:0] Dout,
  input  logic         Dout_valid,
  input  logic         jmp_valid,
  input  logic [31:0]  jmp_addr,
  output logic [31:0]  inst_out,
  output logic [31:0]  inst_pc,
  output logic         inst_valid,
  input  logic         inst_rd,
  output logic         full,
  output logic         empty,
  output logic         fetch_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(RETRY_MAX + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [MW-1:0] LAST_MISS = MW'(RETRY_MAX - 1);

  logic [127:0]  line_mem  [DEPTH];
  logic [27:0]   base_mem  [DEPTH];
  logic [1:0]    start_mem [DEPTH];

  logic [27:0]   pc_line;
  logic [1:0]    start_pend;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    rd_cnt;
  logic [1:0]    eidx;
  logic [MW-1:0] miss_cnt;
  logic          push;
  logic          miss;
  logic          pop;
  logic          free;
  logic          unused_jmp_lsbs;

  assign unused_jmp_lsbs = ^jmp_addr[1:0];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pc_in = {pc_line, 4'h0};
  assign abort = jmp_valid & ~rst;
  // No pop-bypass: a full queue stalls fetch even when the head frees this cycle.
  assign rd_en = ~rst & ~jmp_valid & ~full & ~fetch_err;
  assign push  = rd_en & Dout_valid;
  assign miss  = rd_en & ~Dout_valid;

  // Decode handshake: one instruction transfers in every cycle where inst_valid and
  // inst_rd are both high; inst_out/inst_pc are stable until that transfer happens.
  assign eidx       = start_mem[rd_ptr] + rd_cnt;
  assign inst_out   = line_mem[rd_ptr][{eidx, 5'b0} +: 32];
  assign inst_pc    = {base_mem[rd_ptr], eidx, 2'b00};
  assign inst_valid = ~empty & ~jmp_valid & ~rst;
  assign pop        = inst_rd & inst_valid;
  assign free       = pop & (eidx == 2'd3);

  always_ff @(posedge clk) begin
    if (push) begin
      line_mem[wr_ptr]  <= Dout;
      base_mem[wr_ptr]  <= pc_line;
      start_mem[wr_ptr] <= start_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_line    <= RESET_PC[31:4];
      start_pend <= RESET_PC[3:2];
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      miss_cnt   <= '0;
      fetch_err  <= 1'b0;
    end else if (jmp_valid) begin
      pc_line    <= jmp_addr[31:4];
      start_pend <= jmp_addr[3:2];
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      miss_cnt   <= '0;
      fetch_err  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        pc_line    <= pc_line + 28'd1;
        start_pend <= 2'd0;
        miss_cnt   <= '0;
      end else if (miss) begin
        miss_cnt <= miss_cnt + 1'b1;
        if (miss_cnt == LAST_MISS) fetch_err <= 1'b1;
      end
      if (pop) begin
        if (free) begin
          rd_ptr <= rd_ptr + 1'b1;
          rd_cnt <= 2'd0;
        end else begin
          rd_cnt <= rd_cnt + 2'd1;
        end
      end
      case ({push, free})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, all checked every
// cycle against an instruction-level model (queue of {pc, word} plus words left per line).
module tb_inst_fetch_queue;
  localparam int          DEPTH     = 4;
  localparam int          RETRY_MAX = 8;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic         rd_en;
  logic         abort;
  logic [127:0] Dout;
  logic         Dout_valid;
  logic         jmp_valid;
  logic [31:0]  jmp_addr;
  logic [31:0]  inst_out;
  logic [31:0]  inst_pc;
  logic         inst_valid;
  logic         inst_rd;
  logic         full;
  logic         empty;
  logic         fetch_err;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .RETRY_MAX(RETRY_MAX)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .rd_en(rd_en), .abort(abort),
    .Dout(Dout), .Dout_valid(Dout_valid), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_rd(inst_rd),
    .full(full), .empty(empty), .fetch_err(fetch_err)
  );

  // scoreboard / reference model
  logic [63:0] exp_q[$];   // {pc, instruction} in program order
  int          left_q[$];  // words still queued per buffered line
  logic [31:0] m_pc;
  int          m_miss;
  bit          m_err;
  bit          e_rd_en;
  bit          e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    e_rd_en = !rst && !jmp_valid && (left_q.size() < DEPTH) && !m_err;
    e_valid = !rst && !jmp_valid && (left_q.size() > 0);
    chk("rd_en", {31'b0, rd_en}, {31'b0, e_rd_en});
    chk("abort", {31'b0, abort}, {31'b0, jmp_valid & !rst});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    if (!rst) begin
      chk("pc_in", pc_in, {m_pc[31:4], 4'h0});
      chk("full", {31'b0, full}, {31'b0, left_q.size() == DEPTH});
      chk("empty", {31'b0, empty}, {31'b0, left_q.size() == 0});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      if (e_valid) begin
        chk("inst_pc", inst_pc, exp_q[0][63:32]);
        chk("inst_out", inst_out, exp_q[0][31:0]);
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      exp_q.delete(); left_q.delete();
      m_pc = RESET_PC; m_miss = 0; m_err = 0;
    end else if (jmp_valid) begin
      exp_q.delete(); left_q.delete();
      m_pc = {jmp_addr[31:2], 2'b00}; m_miss = 0; m_err = 0;
    end else begin
      if (e_valid && inst_rd) begin
        void'(exp_q.pop_front());
        left_q[0] = left_q[0] - 1;
        if (left_q[0] == 0) void'(left_q.pop_front());
      end
      if (e_rd_en) begin
        if (Dout_valid) begin
          for (int w = int'(m_pc[3:2]); w < 4; w++)
            exp_q.push_back({m_pc[31:4], 2'(w), 2'b00, Dout[32*w +: 32]});
          left_q.push_back(4 - int'(m_pc[3:2]));
          m_pc = {m_pc[31:4] + 28'd1, 4'h0};
          m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss >= RETRY_MAX) m_err = 1;
        end
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit r, input bit dv, input bit j, input logic [31:0] ja,
                       input bit rd);
    rst = r; Dout_valid = dv; jmp_valid = j; jmp_addr = ja; inst_rd = rd;
    Dout = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
  endtask

  task automatic cycle();
    #2;
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int dv_pct;
    m_pc = RESET_PC; m_miss = 0; m_err = 0;
    drive(1, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0);
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_pc", pc_in, RESET_PC);

    // fill: four consecutive pushes, then stall at 0x40
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0);
      chk("fill_pc", pc_in, 32'(i * 16));
      cycle();
    end
    drive(0, 1, 0, 0, 0);
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_rd_en", {31'b0, rd_en}, 32'd0);
    chk("fill_pc_held", pc_in, 32'h40);
    cycle();

    // drain with continuous pops
    drive(0, 1, 0, 0, 1);
    chk("drain_first_pc", inst_pc, 32'h0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 1);
      cycle();
    end

    // redirect with three lines queued
    drive(0, 0, 1, 32'h200, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0, 0); cycle(); end
    drive(0, 1, 1, 32'h108, 1); cycle();
    drive(0, 1, 0, 0, 0);
    chk("redir_empty", {31'b0, empty}, 32'd1);
    chk("redir_pc_in", pc_in, 32'h100);
    cycle();
    drive(0, 1, 0, 0, 1);
    chk("redir_pc0", inst_pc, 32'h108);
    cycle();
    drive(0, 1, 0, 0, 1);
    chk("redir_pc1", inst_pc, 32'h10C);
    cycle();
    drive(0, 1, 0, 0, 1);
    chk("redir_pc2", inst_pc, 32'h110);
    cycle();

    // miss retry at 0x20
    drive(1, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0, 1); cycle(); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("retry_pc", pc_in, 32'h20);
      cycle();
    end
    drive(0, 1, 0, 0, 1);
    chk("retry_pc_last", pc_in, 32'h20);
    cycle();
    drive(0, 0, 0, 0, 0);
    chk("retry_pc_next", pc_in, 32'h30);
    chk("retry_no_err", {31'b0, fetch_err}, 32'd0);
    cycle();

    // RETRY_MAX misses raise fetch_err; a redirect clears it
    drive(0, 0, 1, 32'h400, 0); cycle();
    for (int i = 0; i < RETRY_MAX; i++) begin drive(0, 0, 0, 0, 0); cycle(); end
    drive(0, 0, 0, 0, 0);
    chk("err_set", {31'b0, fetch_err}, 32'd1);
    chk("err_rd_en", {31'b0, rd_en}, 32'd0);
    cycle();
    drive(0, 0, 1, 32'h500, 0); cycle();
    drive(0, 1, 0, 0, 0);
    chk("err_clear", {31'b0, fetch_err}, 32'd0);
    chk("err_rd_en_back", {31'b0, rd_en}, 32'd1);
    cycle();

    // count = DEPTH-1 with push and freeing pop together
    drive(0, 0, 1, 32'h0C, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0, 0); cycle(); end
    drive(0, 1, 0, 0, 1);
    chk("corner_head_pc", inst_pc, 32'h0C);
    chk("corner_rd_en", {31'b0, rd_en}, 32'd1);
    cycle();
    drive(0, 0, 0, 0, 0);
    chk("corner_not_full", {31'b0, full}, 32'd0);
    chk("corner_not_empty", {31'b0, empty}, 32'd0);
    cycle();
    drive(0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0);
    chk("corner_full", {31'b0, full}, 32'd1);
    cycle();

    // reset and redirect together: reset wins
    drive(1, 1, 1, 32'h700, 1);
    chk("rstjmp_abort", {31'b0, abort}, 32'd0);
    chk("rstjmp_rd_en", {31'b0, rd_en}, 32'd0);
    cycle();
    drive(0, 0, 0, 0, 0);
    chk("rstjmp_pc", pc_in, RESET_PC);
    chk("rstjmp_empty", {31'b0, empty}, 32'd1);
    cycle();

    // random traffic
    dv_pct = 90;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) dv_pct = int'($urandom_range(5, 100));
      drive($urandom_range(0, 199) == 0, $urandom_range(1, 100) <= dv_pct,
            $urandom_range(0, 24) == 0, $urandom(), $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
